mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single shared memory port between the instruction-fetch requester (IF) and the execute-stage load/store requester (EX). It sits between the control FSMs and the MAR/MDR/memory interface, sequences each access through the mem_EN/mem_RW/MFC handshake, and returns read data with a one-cycle acknowledge. Arbitration is round-robin on simultaneous requests, so neither requester can starve the other.

## Interface
- AW, 8, address width
- DW, 8, data width
- TIMEOUT, 15, maximum cycles in ACCESS waiting for MFC (used only with MEM_ARB_TIMEOUT_EN)

- clk  input  1  system clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request, held until if_ack
- if_addr  input  AW  fetch address (always a read)
- if_ack  output  1  one-cycle completion pulse to IF
- ex_req  input  1  execute request, held until ex_ack
- ex_rw  input  1  1 = read, 0 = write
- ex_addr  input  AW  execute address
- ex_wdata  input  DW  execute write data
- ex_ack  output  1  one-cycle completion pulse to EX
- rdata  output  DW  read data, valid in the ack cycle, held until next capture
- mem_addr  output  AW  address to MAR
- mem_wdata  output  DW  write data to MDR
- mem_EN  output  1  memory enable
- mem_RW  output  1  1 = read, 0 = write
- MFC  input  1  memory function complete
- mem_rdata  input  DW  read data from memory
- busy  output  1  high in any state other than IDLE
- grant_ex  output  1  0 = IF owns current access, 1 = EX
- timeout_err  output  1  one-cycle error pulse (present only with MEM_ARB_TIMEOUT_EN)

## Operation
- States: IDLE, ACCESS, RESP; all outputs registered.
- IDLE: no request -> stay. One request -> grant it. Both -> grant the requester not granted last (last_grant flag). On grant: latch mem_addr, mem_wdata (EX only), mem_RW (1 for IF, ex_rw for EX), grant_ex; next state ACCESS.
- ACCESS: mem_EN = 1. MFC sampled high -> capture mem_rdata into rdata if mem_RW = 1, mem_EN = 0, update last_grant, go RESP. MFC low -> stay.
- RESP: pulse if_ack or ex_ack per grant_ex; go IDLE. mem_EN low for at least one cycle between accesses.
- Write accesses leave rdata unchanged.
- Request inputs only sampled in IDLE; address/data changes after grant are ignored.
- MFC ignored in IDLE and RESP.
- Reset values: state IDLE, last_grant = EX (so IF wins the first tie), if_ack = ex_ack = 0, mem_EN = 0, mem_RW = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, busy = 0, grant_ex = 0, timeout_err = 0, timeout counter 0.
- rst mid-access: next edge returns to IDLE, mem_EN drops, no ack issued, last_grant reset.

## Timing
- Request sampled at edge N (IDLE) -> ACCESS from edge N+1, mem_EN high.
- MFC high sampled at edge N+2 -> RESP from edge N+2, ack high for cycle N+2..N+3.
- Minimum request-to-ack latency 2 cycles; each extra MFC wait cycle adds 1.
- Minimum issue rate: one access every 3 cycles (IDLE, ACCESS, RESP).
- Requester drops req on the edge after seeing ack; req still high in the following IDLE is a new request.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: counter runs in ACCESS; if TIMEOUT cycles elapse without MFC, mem_EN drops, state goes RESP, ack issued normally, timeout_err pulses with the ack, rdata set to all ones for reads. Counter clears on entering ACCESS.
- Undefined: no counter, no timeout_err port; ACCESS waits indefinitely for MFC.

## Test plan
- Reset then if_req=1, if_addr=0x10, MFC returned 1 cycle after mem_EN with mem_rdata=0xA5 -> mem_addr=0x10, mem_RW=1, if_ack pulse 3 cycles after req, rdata=0xA5.
- if_req and ex_req both high after reset -> IF served first, then EX; repeat tie -> IF, EX alternate; no requester granted twice while the other waits.
- EX write ex_rw=0, ex_addr=0x22, ex_wdata=0x3C, MFC delayed 4 cycles -> mem_EN high 5 cycles, mem_RW=0, mem_wdata=0x3C, ex_ack once, rdata unchanged.
- rst asserted during ACCESS -> next cycle mem_EN=0, busy=0, no ack; subsequent tie grants IF.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=15, MFC never asserted on IF read -> mem_EN high 15 cycles, if_ack and timeout_err pulse together, rdata=0xFF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port between fetch (IF) and execute (EX) requesters.
// Optional MFC timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    input  logic          ex_req,
    input  logic          ex_rw,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_wdata,
    output logic          ex_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_EN,
    output logic          mem_RW,
    input  logic          MFC,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic          timeout_err,
`endif
    output logic          grant_ex
);

    // state  | meaning
    // IDLE   | port free, requests sampled
    // ACCESS | mem_EN high, waiting for MFC
    // RESP   | ack pulse to the granted requester
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_n;
    logic          last_grant, last_grant_n;
    logic          if_ack_n, ex_ack_n, mem_en_n, mem_rw_n, busy_n, grant_ex_n;
    logic [DW-1:0] rdata_n, mem_wdata_n;
    logic [AW-1:0] mem_addr_n;
    logic          pick_ex, tmo, done;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          timeout_err_n;
`endif

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        if_ack_n     = 1'b0;
        ex_ack_n     = 1'b0;
        mem_en_n     = mem_EN;
        mem_rw_n     = mem_RW;
        grant_ex_n   = grant_ex;
        rdata_n      = rdata;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        pick_ex      = 1'b0;
        tmo          = 1'b0;
        done         = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_n         = cnt;
        timeout_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (if_req || ex_req) begin
                    // last_grant = 1 means EX went last, so IF wins a tie
                    pick_ex    = ex_req && (!if_req || !last_grant);
                    grant_ex_n = pick_ex;
                    mem_addr_n = pick_ex ? ex_addr : if_addr;
                    mem_rw_n   = pick_ex ? ex_rw : 1'b1;
                    if (pick_ex)
                        mem_wdata_n = ex_wdata;
                    mem_en_n   = 1'b1;
                    state_n    = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_n      = '0;
`endif
                end
            end
            ACCESS: begin
`ifdef MEM_ARB_TIMEOUT_EN
                tmo = !MFC && (cnt == CW'(TIMEOUT - 1));
                if (!MFC && !tmo)
                    cnt_n = cnt + 1'b1;
                timeout_err_n = tmo;
`endif
                done = MFC || tmo;
                if (done) begin
                    if (mem_RW)
                        rdata_n = tmo ? '1 : mem_rdata;
                    mem_en_n     = 1'b0;
                    last_grant_n = grant_ex;
                    if_ack_n     = !grant_ex;
                    ex_ack_n     = grant_ex;
                    state_n      = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            if_ack     <= 1'b0;
            ex_ack     <= 1'b0;
            mem_EN     <= 1'b0;
            mem_RW     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            grant_ex   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            if_ack     <= if_ack_n;
            ex_ack     <= ex_ack_n;
            mem_EN     <= mem_en_n;
            mem_RW     <= mem_rw_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            rdata      <= rdata_n;
            busy       <= busy_n;
            grant_ex   <= grant_ex_n;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt         <= cnt_n;
            timeout_err <= timeout_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; timeout checks run only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       if_req, ex_req, ex_rw, MFC;
    logic [7:0] if_addr, ex_addr, ex_wdata, mem_rdata;
    logic       if_ack, ex_ack, mem_EN, mem_RW, busy, grant_ex;
    logic [7:0] rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .ex_req(ex_req), .ex_rw(ex_rw), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_ack(ex_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_EN(mem_EN), .mem_RW(mem_RW), .MFC(MFC), .mem_rdata(mem_rdata),
        .busy(busy),
`ifdef MEM_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .grant_ex(grant_ex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; ex_req = 1'b0; ex_rw = 1'b0; MFC = 1'b0;
        if_addr = 8'h00; ex_addr = 8'h00; ex_wdata = 8'h00; mem_rdata = 8'h00;
        step(); step();
        chk("rst_busy", busy, 0);     chk("rst_en", mem_EN, 0);   chk("rst_rw", mem_RW, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_rdata", rdata, 0); chk("rst_ifack", if_ack, 0);
        chk("rst_gnt", grant_ex, 0);  chk("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        // MFC while idle must do nothing
        MFC = 1'b1; step();
        chk("idle_mfc_busy", busy, 0); chk("idle_mfc_en", mem_EN, 0); chk("idle_mfc_ack", if_ack, 0);
        MFC = 1'b0;

        // single IF read, MFC one cycle after mem_EN
        if_req = 1'b1; if_addr = 8'h10; step();
        chk("t1_en", mem_EN, 1); chk("t1_addr", mem_addr, 8'h10); chk("t1_rw", mem_RW, 1);
        chk("t1_busy", busy, 1); chk("t1_gnt", grant_ex, 0);
        if_addr = 8'hEE; step();
        chk("t1_wait_en", mem_EN, 1); chk("t1_wait_ack", if_ack, 0); chk("t1_addr_hold", mem_addr, 8'h10);
        MFC = 1'b1; mem_rdata = 8'hA5; step();
        chk("t1_ack", if_ack, 1); chk("t1_exack", ex_ack, 0); chk("t1_rdata", rdata, 8'hA5);
        chk("t1_en_off", mem_EN, 0); chk("t1_resp_busy", busy, 1);
        if_req = 1'b0; MFC = 1'b0; step();
        chk("t1_ack_off", if_ack, 0); chk("t1_idle", busy, 0); chk("t1_rdata_hold", rdata, 8'hA5);

        // ties after reset alternate IF, EX, IF, EX
        rst = 1'b1; step(); rst = 1'b0;
        chk("t2_rst_rdata", rdata, 0);
        if_req = 1'b1; if_addr = 8'h30; ex_req = 1'b1; ex_rw = 1'b1; ex_addr = 8'h40;
        step();
        chk("t2_g1", grant_ex, 0); chk("t2_a1", mem_addr, 8'h30);
        MFC = 1'b1; mem_rdata = 8'h11; step();
        chk("t2_ifack1", if_ack, 1); chk("t2_exack1", ex_ack, 0); chk("t2_rd1", rdata, 8'h11);
        if_req = 1'b0; MFC = 1'b0; step();
        chk("t2_gap_busy", busy, 0); chk("t2_gap_en", mem_EN, 0);
        step();
        chk("t2_g2", grant_ex, 1); chk("t2_a2", mem_addr, 8'h40); chk("t2_rw2", mem_RW, 1);
        if_req = 1'b1; MFC = 1'b1; mem_rdata = 8'h22; step();
        chk("t2_exack2", ex_ack, 1); chk("t2_ifack2", if_ack, 0); chk("t2_rd2", rdata, 8'h22);
        MFC = 1'b0; step(); step();
        chk("t2_g3", grant_ex, 0);
        MFC = 1'b1; mem_rdata = 8'h33; step();
        chk("t2_ifack3", if_ack, 1); chk("t2_rd3", rdata, 8'h33);
        MFC = 1'b0; step(); step();
        chk("t2_g4", grant_ex, 1);
        MFC = 1'b1; mem_rdata = 8'h44; step();
        chk("t2_exack4", ex_ack, 1); chk("t2_rd4", rdata, 8'h44);
        if_req = 1'b0; ex_req = 1'b0; MFC = 1'b0; step();

        // EX write with MFC four cycles late
        ex_req = 1'b1; ex_rw = 1'b0; ex_addr = 8'h22; ex_wdata = 8'h3C; mem_rdata = 8'h77;
        step();
        chk("t3_gnt", grant_ex, 1); chk("t3_rw", mem_RW, 0); chk("t3_wdata", mem_wdata, 8'h3C);
        chk("t3_addr", mem_addr, 8'h22); chk("t3_en", mem_EN, 1);
        ex_addr = 8'h99; ex_wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t3_wait_en%0d", i), mem_EN, 1);
            chk($sformatf("t3_wait_ack%0d", i), ex_ack, 0);
        end
        MFC = 1'b1; step();
        chk("t3_ack", ex_ack, 1); chk("t3_en_off", mem_EN, 0); chk("t3_rdata_hold", rdata, 8'h44);
        chk("t3_addr_hold", mem_addr, 8'h22); chk("t3_wdata_hold", mem_wdata, 8'h3C);
        ex_req = 1'b0; MFC = 1'b0; step();
        chk("t3_ack_off", ex_ack, 0); chk("t3_idle", busy, 0);

        // IF read so last_grant = IF, then reset during an EX access
        if_req = 1'b1; if_addr = 8'h60; step();
        MFC = 1'b1; mem_rdata = 8'h5A; step();
        chk("t4_ifack", if_ack, 1); chk("t4_rdata", rdata, 8'h5A);
        if_req = 1'b0; MFC = 1'b0; step();
        ex_req = 1'b1; ex_rw = 1'b1; ex_addr = 8'h80; step();
        chk("t4_gnt_ex", grant_ex, 1); chk("t4_en", mem_EN, 1);
        rst = 1'b1; step();
        chk("t4_rst_en", mem_EN, 0); chk("t4_rst_busy", busy, 0);
        chk("t4_rst_exack", ex_ack, 0); chk("t4_rst_ifack", if_ack, 0);
        rst = 1'b0; if_req = 1'b1; if_addr = 8'h61; step();
        chk("t4_tie_gnt", grant_ex, 0); chk("t4_tie_addr", mem_addr, 8'h61);
        MFC = 1'b1; mem_rdata = 8'hC3; step();
        chk("t4_tie_ack", if_ack, 1); chk("t4_tie_exack", ex_ack, 0); chk("t4_tie_rdata", rdata, 8'hC3);
        if_req = 1'b0; ex_req = 1'b0; MFC = 1'b0; step();

`ifdef MEM_ARB_TIMEOUT_EN
        // MFC never arrives on an IF read
        rst = 1'b1; step(); rst = 1'b0;
        if_req = 1'b1; if_addr = 8'h70; step();
        chk("t5_en0", mem_EN, 1);
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("t5_en%0d", i + 1), mem_EN, 1);
            chk($sformatf("t5_noack%0d", i + 1), if_ack, 0);
            chk($sformatf("t5_noerr%0d", i + 1), timeout_err, 0);
        end
        step();
        chk("t5_ack", if_ack, 1); chk("t5_err", timeout_err, 1);
        chk("t5_rdata", rdata, 8'hFF); chk("t5_en_off", mem_EN, 0);
        if_req = 1'b0; step();
        chk("t5_err_off", timeout_err, 0); chk("t5_ack_off", if_ack, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
